// File: rtl/pulse_train_gen_if.sv
// Control/status bundle for pulse_train_gen: a start request with its pulse
// count, plus the generated train, progress/completion flags and FSM state.
interface pulse_train_gen_if #(
    parameter int CNT_W = 8
);
    // start is a single-cycle request with no ready: the block accepts it only
    // when idle (busy=0, including the done cycle) and num is captured then;
    // requests seen while busy are dropped, never queued.
    logic             start;
    logic [CNT_W-1:0] num;
    logic             sig_out;
    logic             busy;
    logic             done;
    logic [1:0]       state_dbg;

    modport master (
        output start, num,
        input  sig_out, busy, done, state_dbg
    );

    modport slave (
        input  start, num,
        output sig_out, busy, done, state_dbg
    );
endinterface

// File: rtl/pulse_train_gen.sv
// Emits num rectangular pulses (HIGH_CYCLES high, LOW_CYCLES low each) after a
// start request, then strobes done for one cycle.
module pulse_train_gen #(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 4,
    parameter int CNT_W       = 8
) (
    input logic              clk,
    input logic              rst,
    pulse_train_gen_if.slave bus
);
    localparam int MAX_CYC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int PH_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [PH_W-1:0] HIGH_LAST = PH_W'(HIGH_CYCLES - 1);
    localparam logic [PH_W-1:0] LOW_LAST  = PH_W'(LOW_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             sig_q, sig_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        remaining_d = remaining_q;
        sig_d       = sig_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // A zero-length train completes immediately with no pulse.
                    if (bus.num == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = ST_HIGH;
                        sig_d       = 1'b1;
                        busy_d      = 1'b1;
                        remaining_d = bus.num;
                        phase_d     = '0;
                    end
                end
            end
            ST_HIGH: begin
                if (phase_q == HIGH_LAST) begin
                    state_d = ST_LOW;
                    sig_d   = 1'b0;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_LOW: begin
                if (phase_q == LOW_LAST) begin
                    phase_d = '0;
                    if (remaining_q == CNT_W'(1)) begin
                        state_d     = ST_IDLE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        remaining_d = '0;
                    end else begin
                        state_d     = ST_HIGH;
                        sig_d       = 1'b1;
                        remaining_d = remaining_q - CNT_W'(1);
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                sig_d   = 1'b0;
                busy_d  = 1'b0;
                phase_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            remaining_q <= '0;
            sig_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            remaining_q <= remaining_d;
            sig_q       <= sig_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.sig_out   = sig_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_pulse_train_gen.sv
// Randomised and directed stimulus for pulse_train_gen, checked cycle by cycle
// against a timeline model plus a per-train rising-edge count.
module tb_pulse_train_gen;
    localparam int H     = 2;
    localparam int L     = 3;
    localparam int P     = H + L;
    localparam int CNT_W = 8;

    logic clk;
    logic rst;

    pulse_train_gen_if #(.CNT_W(CNT_W)) bus ();

    pulse_train_gen #(
        .HIGH_CYCLES(H),
        .LOW_CYCLES (L),
        .CNT_W      (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [2:0] exp_q[$];     // {sig_out, busy, done} expected after each edge
    int         train_q[$];   // pulses expected per accepted request
    int         checks = 0;
    int         errors = 0;

    // reference: a train is "num pulses laid out on a time line of period P"
    bit         m_active = 1'b0;
    int         m_t = 0;
    int         m_n = 0;

    task automatic step(input logic r, input logic s, input logic [CNT_W-1:0] n);
        logic [2:0] e;
        @(negedge clk);
        rst       = r;
        bus.start = s;
        bus.num   = n;
        e = 3'b000;
        if (r) begin
            m_active = 1'b0;
            train_q.delete();
        end else if (m_active) begin
            m_t++;
            if (m_t < m_n * P) begin
                e = {((m_t % P) < H), 1'b1, 1'b0};
            end else begin
                m_active = 1'b0;
                e = 3'b001;
            end
        end else if (s) begin
            train_q.push_back(int'(n));
            if (n == '0) begin
                e = 3'b001;
            end else begin
                m_active = 1'b1;
                m_t = 0;
                m_n = int'(n);
                e = 3'b110;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, '0);
    endtask

    // ---------------- monitor ----------------
    int   rise_cnt = 0;
    logic prev_sig = 1'b0;
    int   cyc = 0;

    initial begin
        logic [2:0] got;
        logic [2:0] e;
        int         want;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {bus.sig_out, bus.busy, bus.done};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d sig/busy/done got=%b exp=%b", cyc, got, e);
                end
                if (rst) begin
                    rise_cnt = 0;
                end else begin
                    if (bus.sig_out === 1'b1 && prev_sig === 1'b0) rise_cnt++;
                    if (bus.done === 1'b1) begin
                        checks++;
                        if (train_q.size() == 0) begin
                            errors++;
                            $display("FAIL train_pulses cyc=%0d done with no pending request, pulses got=%0d", cyc, rise_cnt);
                        end else begin
                            want = train_q.pop_front();
                            if (rise_cnt != want) begin
                                errors++;
                                $display("FAIL train_pulses cyc=%0d got=%0d exp=%0d", cyc, rise_cnt, want);
                            end
                        end
                        rise_cnt = 0;
                    end
                end
                prev_sig = bus.sig_out;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [CNT_W-1:0] n;
        logic             r;
        logic             s;
        int               guard;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.num   = '0;

        // reset, including a start that reset must override
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 8'd3);
        step(1'b1, 1'b0, '0);
        idle(2);

        // basic train
        step(1'b0, 1'b1, 8'd3);
        idle(3 * P + 2);

        // zero count
        step(1'b0, 1'b1, 8'd0);
        idle(3);

        // retrigger while busy is ignored
        step(1'b0, 1'b1, 8'd2);
        idle(2);
        step(1'b0, 1'b1, 8'd7);
        idle(2 * P + 3);

        // back-to-back: new start lands in the done cycle
        step(1'b0, 1'b1, 8'd2);
        idle(2 * P);
        step(1'b0, 1'b1, 8'd1);
        idle(P + 3);

        // reset mid-train, then a fresh train
        step(1'b0, 1'b1, 8'd5);
        idle(6);
        step(1'b1, 1'b0, '0);
        idle(3);
        step(1'b0, 1'b1, 8'd2);
        idle(2 * P + 2);

        // random traffic with occasional resets and ignored retriggers
        for (int i = 0; i < 700; i++) begin
            r = ($urandom_range(0, 149) == 0);
            s = ($urandom_range(0, 7) == 0);
            n = CNT_W'($urandom_range(0, 6));
            step(r, s, n);
        end
        idle(40);

        // maximum count, with random start noise while busy
        step(1'b0, 1'b1, 8'd255);
        for (int i = 0; i < 255 * P + 2; i++) begin
            s = ($urandom_range(0, 19) == 0);
            n = CNT_W'($urandom_range(0, 6));
            step(1'b0, s, n);
        end
        idle(40);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0 || train_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending_outputs=%0d pending_trains=%0d exp=0/0", exp_q.size(), train_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
Transmit-side counterpart to the rising-edge detector used on button/switch inputs. On a one-cycle start request, the block emits a train of N clean rectangular pulses on a single output line. Each pulse has a parameterised high width and low gap. The block drives LED/IO stimulus or feeds edge-counting logic in the lab designs.

Parameters:
HIGH_CYCLES, 4, clock cycles sig_out stays high per pulse (≥1)
LOW_CYCLES, 4, clock cycles sig_out stays low after each pulse (≥1)
CNT_W, 8, width of pulse-count input and internal remaining-pulse counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
num  input  CNT_W  number of pulses; latched when start is accepted
sig_out  output  1  generated pulse train (registered)
busy  output  1  high while a train is in progress (registered)
done  output  1  one-cycle completion strobe (registered)

Behaviour:
- Single clock domain, synchronous active-high reset.
- Reset values: sig_out=0, busy=0, done=0, state=IDLE, all counters 0.
- Outputs are registered directly from state/counter logic; no combinational path from start/num to any output.
- States: IDLE, HIGH, LOW.
- Phase counter width: $clog2 of max(HIGH_CYCLES, LOW_CYCLES), minimum 1 bit.
- Remaining-pulse counter: CNT_W bits, loaded with num on accept, decremented at the end of each LOW phase.

Timing (edge 0 = edge where start=1 is sampled in IDLE):
- IDLE, start=1, num≠0:
  - At edge 0: state→HIGH, sig_out←1, busy←1, remaining←num, phase←0.
- HIGH:
  - sig_out held 1 for exactly HIGH_CYCLES cycles.
  - On the last one: state→LOW, sig_out←0, phase←0.
- LOW:
  - sig_out held 0 for exactly LOW_CYCLES cycles.
  - On the last one with remaining>1: remaining decrements, state→HIGH, sig_out←1.
  - On the last one with remaining==1: state→IDLE, busy←0, done←1 for one cycle.
- Total busy duration: exactly num*(HIGH_CYCLES+LOW_CYCLES) cycles. done asserts in the first cycle busy is 0.
- done is 1 for exactly one cycle, then returns to 0.

Boundary conditions:
- num==0 with start: no pulse; sig_out and busy stay 0; done←1 at edge 0 (visible for one cycle).
- num at maximum (2^CNT_W−1): full count emitted; no wrap.
- start while busy: ignored; num changes while busy have no effect.
- start in the cycle done is high: block is already IDLE, so start is accepted normally.
- rst mid-train: next edge forces reset values; sig_out drops immediately (registered); no done strobe.
- rst and start together: rst wins.

Test Plan:
- Basic train: H=2, L=3, start with num=3 at edge 0 -> sig_out=1 in cycles 0-1, 5-6, 10-11, 0 elsewhere; busy=1 in cycles 0-14; done=1 only in cycle 15.
- Zero count: start with num=0 -> sig_out and busy stay 0; done=1 for exactly one cycle (cycle 0).
- Ignored retrigger: num=2 train running; pulse start with num=7 in cycle 3 -> exactly 2 pulses; busy=1 for 2*(H+L) cycles; one done.
- Back-to-back: assert start in the done cycle with num=1 -> new HIGH phase begins at that edge; total rising edges on sig_out = 1 + previous num.
- Reset mid-operation: num=5, assert rst in cycle 7 for one cycle -> next cycle sig_out=0, busy=0, done=0; block stays idle until a new start; a later start with num=2 yields exactly 2 pulses.
- Defaults with loopback: H=L=4, num=255 -> a rising-edge counter on sig_out reads 255; busy lasts 2040 cycles; single done.
